split_eval_seq: RTL and testbench

Sequential, parametrised successor to the fixed-arity constant split constraint blocks. It consumes one frame of NUM_VARS variable assignments streamed one word per cycle. At end of frame it evaluates a run-time-selected constraint mode and returns a single satisfaction bit `x` through a valid/ready handshake. It sits between the assignment generator and the BDD solver's split combiner, replacing wide flat input ports with a narrow stream.

---
 rtl/split_eval_seq.sv | 139 +++++++++++++
 tb/tb_split_eval_seq.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/split_eval_seq.sv
// split_eval_seq: streams one frame of NUM_VARS variable words, evaluates a
// constraint mode latched at frame start, and returns the satisfaction bit x
// (with len_err) through a valid/ready handshake.
// Optional feature macro: SPLIT_EVAL_STATS_EN adds frames_ok / frames_err
// result counters.
module split_eval_seq #(
  parameter int NUM_VARS = 150,
  parameter int VAR_W    = 16,
  parameter int CNT_W    = $clog2(NUM_VARS + 1),
  parameter int ACC_W    = VAR_W + CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic [ACC_W-1:0] sum_max,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [VAR_W-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             x,
`ifdef SPLIT_EVAL_STATS_EN
  output logic [15:0]      frames_ok,
  output logic [15:0]      frames_err,
`endif
  output logic             len_err
);

  // Counter needs to hold NUM_VARS+1 (the saturation value marking "too long").
  localparam int SW = $clog2(NUM_VARS + 2);
  localparam logic [SW-1:0] CNT_TGT = SW'(NUM_VARS);
  localparam logic [SW-1:0] CNT_SAT = SW'(NUM_VARS + 1);

  localparam logic [1:0] M_TRUE = 2'd0, M_SUM_LE = 2'd1, M_ALL_NZ = 2'd2;

  typedef enum logic [1:0] {IDLE, ACCUM, RESULT} state_t;

  state_t           state, state_nxt;
  logic             in_ready_q;
  logic [SW-1:0]    cnt, cnt_nxt;
  logic [ACC_W-1:0] sum, sum_nxt;
  logic             nz, nz_nxt;
  logic [1:0]       mode_q, mode_eff;
  logic [ACC_W-1:0] max_q, max_eff;
  logic             x_q, len_q;
  logic             raw, len_nxt;
  logic             in_fire, first;

  assign in_fire   = in_valid & in_ready_q;
  assign first     = (state == IDLE);
  assign in_ready  = in_ready_q;
  assign out_valid = (state == RESULT);
  assign x         = x_q;
  assign len_err   = len_q;

  // Accumulator update for the word on the bus; first word of a frame seeds
  // the accumulators and uses the live mode/sum_max (they are latched with it).
  always_comb begin
    mode_eff = first ? mode : mode_q;
    max_eff  = first ? sum_max : max_q;
    if (first) begin
      cnt_nxt = SW'(1);
      sum_nxt = ACC_W'(in_data);
      nz_nxt  = (in_data != '0);
    end else begin
      cnt_nxt = (cnt == CNT_SAT) ? cnt : cnt + SW'(1);
      sum_nxt = sum + ACC_W'(in_data);
      nz_nxt  = nz & (in_data != '0);
    end
    len_nxt = (cnt_nxt != CNT_TGT);
    case (mode_eff)
      M_TRUE:   raw = 1'b1;
      M_SUM_LE: raw = (sum_nxt <= max_eff);
      M_ALL_NZ: raw = nz_nxt;
      default:  raw = 1'b0;
    endcase
  end

  // Next-state: frame ends on an accepted in_last word, result leaves on transfer.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_fire) state_nxt = in_last ? RESULT : ACCUM;
      ACCUM:   if (in_fire && in_last) state_nxt = RESULT;
      RESULT:  if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, registered in_ready, accumulators and the held result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      in_ready_q <= 1'b1;
      cnt        <= '0;
      sum        <= '0;
      nz         <= 1'b0;
      mode_q     <= '0;
      max_q      <= '0;
      x_q        <= 1'b0;
      len_q      <= 1'b0;
    end else begin
      state      <= state_nxt;
      in_ready_q <= (state_nxt != RESULT);
      if (in_fire) begin
        cnt <= cnt_nxt;
        sum <= sum_nxt;
        nz  <= nz_nxt;
        if (first) begin
          mode_q <= mode;
          max_q  <= sum_max;
        end
        if (in_last) begin
          x_q   <= raw & ~len_nxt;
          len_q <= len_nxt;
        end
      end
    end
  end

`ifdef SPLIT_EVAL_STATS_EN
  logic [15:0] ok_q, err_q;
  assign frames_ok  = ok_q;
  assign frames_err = err_q;

  // Count delivered results; both counters wrap naturally at 2^16.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ok_q  <= '0;
      err_q <= '0;
    end else if (out_valid && out_ready) begin
      if (x_q)   ok_q  <= ok_q + 16'd1;
      if (len_q) err_q <= err_q + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_split_eval_seq.sv
// Directed bench for split_eval_seq (NUM_VARS=150, VAR_W=16).
module tb_split_eval_seq;
  localparam int NV = 150;
  localparam int AW = 24;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    mode;
  logic [AW-1:0] sum_max;
  logic          in_valid, in_ready, in_last;
  logic [15:0]   in_data;
  logic          out_valid, out_ready, x, len_err;
`ifdef SPLIT_EVAL_STATS_EN
  logic [15:0]   frames_ok, frames_err;
  int            exp_ok = 0, exp_err = 0;
`endif

  int checks = 0;
  int failures = 0;

  split_eval_seq #(.NUM_VARS(NV), .VAR_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sum_max(sum_max),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .x(x),
`ifdef SPLIT_EVAL_STATS_EN
    .frames_ok(frames_ok), .frames_err(frames_err),
`endif
    .len_err(len_err)
  );

  always #5 clk = ~clk;

  // Stream n words, one per cycle. kind 0: arbitrary nonzero, kind 1: all 10.
  // Word zidx (1-based) is forced to 0. mode/sum_max are scrambled after word 1.
  task automatic send_frame(input int n, input logic [1:0] m, input logic [AW-1:0] mx,
                            input int kind, input int zidx, input bit with_last);
    for (int i = 1; i <= n; i++) begin
      in_valid = 1'b1;
      in_data  = (kind == 1) ? 16'd10 : (16'((i * 37) % 65536) | 16'd1);
      if (i == zidx) in_data = 16'd0;
      in_last  = with_last && (i == n);
      mode     = (i == 1) ? m : (m ^ 2'b11);
      sum_max  = (i == 1) ? mx : ~mx;
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("FAIL in_ready word %0d: got %b want 1", i, in_ready);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Called #1 after the in_last edge: result must be up now; out_ready=1 takes it.
  task automatic check_result(input string nm, input logic ex, input logic el);
    checks++;
    if (out_valid !== 1'b1 || x !== ex || len_err !== el) begin
      failures++;
      $display("FAIL %s: got v=%b x=%b len=%b want v=1 x=%b len=%b",
               nm, out_valid, x, len_err, ex, el);
    end
`ifdef SPLIT_EVAL_STATS_EN
    if (ex) exp_ok++;
    if (el) exp_err++;
`endif
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_after: got v=%b rdy=%b want v=0 rdy=1", nm, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 0; in_last = 0; in_data = 0; mode = 0; sum_max = 0; out_ready = 1;
    #12;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || x !== 1'b0 || len_err !== 1'b0) begin
      failures++;
      $display("FAIL reset: got rdy=%b v=%b x=%b len=%b want 1 0 0 0", in_ready, out_valid, x, len_err);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_true_latency();
    // Word 1 presented in cycle 1; out_valid must be up in cycle 151.
    send_frame(NV, 2'd0, '0, 0, 0, 1);
    check_result("mode_true", 1'b1, 1'b0);
  endtask

  task automatic test_sum_le();
    send_frame(NV, 2'd1, 24'd1500, 1, 0, 1);
    check_result("sum_le_eq", 1'b1, 1'b0);
    send_frame(NV, 2'd1, 24'd1499, 1, 0, 1);
    check_result("sum_le_over", 1'b0, 1'b0);
  endtask

  task automatic test_all_nz();
    send_frame(NV, 2'd2, '0, 0, 73, 1);
    check_result("all_nz_zero73", 1'b0, 1'b0);
    send_frame(NV, 2'd2, '0, 0, 0, 1);
    check_result("all_nz_ok", 1'b1, 1'b0);
    send_frame(NV, 2'd3, '0, 0, 0, 1);
    check_result("mode_false", 1'b0, 1'b0);
  endtask

  task automatic test_len_err();
    send_frame(NV - 1, 2'd0, '0, 0, 0, 1);
    check_result("short_149", 1'b0, 1'b1);
    send_frame(200, 2'd0, '0, 0, 0, 1);
    check_result("long_200", 1'b0, 1'b1);
    send_frame(1, 2'd0, '0, 0, 0, 1);
    check_result("single_word", 1'b0, 1'b1);
    send_frame(NV, 2'd0, '0, 0, 0, 1);
    check_result("after_err_ok", 1'b1, 1'b0);
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send_frame(NV, 2'd1, 24'd1499, 1, 0, 1);
    for (int c = 0; c < 20; c++) begin
      checks++;
      if (out_valid !== 1'b1 || x !== 1'b0 || len_err !== 1'b0 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold cyc %0d: got v=%b x=%b len=%b rdy=%b want 1 0 0 0",
                 c, out_valid, x, len_err, in_ready);
      end
      @(posedge clk); #1;
    end
    check_result("held_result", 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_frame();
    send_frame(80, 2'd0, '0, 0, 0, 0);
    rst_n = 1'b0; #2; rst_n = 1'b1;
`ifdef SPLIT_EVAL_STATS_EN
    exp_ok = 0; exp_err = 0;
`endif
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        failures++;
        $display("FAIL post_reset cyc %0d: got v=%b rdy=%b want 0 1", c, out_valid, in_ready);
      end
    end
    send_frame(NV, 2'd2, '0, 0, 0, 1);
    check_result("clean_after_reset", 1'b1, 1'b0);
    send_frame(NV - 1, 2'd0, '0, 0, 0, 1);
    check_result("err_after_reset", 1'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_true_latency();
    test_sum_le();
    test_all_nz();
    test_len_err();
    test_backpressure();
    test_reset_mid_frame();
`ifdef SPLIT_EVAL_STATS_EN
    checks++;
    if (int'(frames_ok) != exp_ok || int'(frames_err) != exp_err) begin
      failures++;
      $display("FAIL stats: got ok=%0d err=%0d want ok=%0d err=%0d",
               frames_ok, frames_err, exp_ok, exp_err);
    end
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
